i2s_dac_tx: RTL and testbench



---
 rtl/i2s_dac_tx.sv | 180 ++++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// I2S transmitter: pairs mixer beats into stereo words, buffers them in a small
// FIFO and serialises them in Philips I2S format with 32 BCLK slots per channel.
module i2s_dac_tx #(
    parameter int AUDIO_WIDTH_P = 24,
    parameter int FIFO_DEPTH_P  = 4,
    parameter int BCLK_HALF_P   = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AUDIO_WIDTH_P-1:0]      dac_data,
    input  logic                          dac_valid,
    output logic                          dac_ready,
    input  logic                          dac_last,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata,
    output logic                          frame_strobe,
    input  logic                          cmd_clear_status,
    output logic [15:0]                   sr_underrun_cnt,
    output logic                          sr_framing_error,
    output logic [$clog2(FIFO_DEPTH_P):0] sr_fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH_P);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BCLK_HALF_P);
    localparam int IW = $clog2(AUDIO_WIDTH_P + 1);
    localparam int PW = 2 * AUDIO_WIDTH_P;

    typedef enum logic {EXPECT_L, EXPECT_R} asm_state_e;

    asm_state_e               asm_q;
    logic [AUDIO_WIDTH_P-1:0] left_q;
    logic [PW-1:0]            mem_q [FIFO_DEPTH_P];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]            level_q, level_d;
    logic                     dac_ready_q;

    logic [CW-1:0]            div_q;
    logic                     bclk_q, lrclk_q, sdata_q, strobe_q, started_q;
    logic [5:0]               bit_cnt_q;
    logic [AUDIO_WIDTH_P-1:0] play_l_q, play_r_q;

    logic [15:0]              underrun_q;
    logic                     framing_q;

    logic                     beat, push, pop, fifo_empty;
    logic                     div_tc, bclk_fall, boundary;
    logic                     framing_set, underrun_inc;
    logic [5:0]               bit_nxt;
    logic [4:0]               slot_pos;
    logic [IW-1:0]            sd_idx;
    logic [AUDIO_WIDTH_P-1:0] word_sel;
    logic                     sdata_d;

    assign beat       = dac_valid && dac_ready_q;
    assign push       = beat && (asm_q == EXPECT_R) && dac_last;
    assign fifo_empty = (level_q == '0);

    assign div_tc    = (div_q == CW'(BCLK_HALF_P - 1));
    assign bclk_fall = div_tc && bclk_q;
    assign boundary  = bclk_fall && (bit_cnt_q == 6'd63);
    // Pop decision uses the pre-push level: a pair arriving in the boundary
    // cycle is never bypassed into the frame that is starting.
    assign pop       = boundary && !fifo_empty;

    assign framing_set  = beat && (((asm_q == EXPECT_L) && dac_last) ||
                                   ((asm_q == EXPECT_R) && !dac_last));
    assign underrun_inc = boundary && fifo_empty && started_q;

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !push)
            level_d = level_q - LW'(1);
    end

    // Serial bit for the slot position the pins move to on this falling edge.
    assign bit_nxt  = bit_cnt_q + 6'd1;
    assign slot_pos = bit_nxt[4:0];
    assign word_sel = bit_nxt[5] ? play_r_q : play_l_q;
    assign sd_idx   = IW'(AUDIO_WIDTH_P - int'(slot_pos));

    always_comb begin
        sdata_d = 1'b0;
        if ((slot_pos != 5'd0) && (slot_pos <= 5'(AUDIO_WIDTH_P)))
            sdata_d = word_sel[sd_idx];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {left_q, dac_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q       <= EXPECT_L;
            left_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            dac_ready_q <= 1'b0;
            div_q       <= '0;
            bclk_q      <= 1'b0;
            bit_cnt_q   <= 6'd63;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            strobe_q    <= 1'b0;
            started_q   <= 1'b0;
            play_l_q    <= '0;
            play_r_q    <= '0;
            underrun_q  <= '0;
            framing_q   <= 1'b0;
        end else begin
            level_q     <= level_d;
            dac_ready_q <= (level_d < LW'(FIFO_DEPTH_P));
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);

            if (beat) begin
                case (asm_q)
                    EXPECT_L: begin
                        if (!dac_last) begin
                            left_q <= dac_data;
                            asm_q  <= EXPECT_R;
                        end
                    end
                    EXPECT_R: begin
                        if (dac_last)
                            asm_q <= EXPECT_L;
                        else
                            left_q <= dac_data;
                    end
                    default: asm_q <= EXPECT_L;
                endcase
            end

            div_q    <= div_tc ? '0 : div_q + CW'(1);
            bclk_q   <= bclk_q ^ div_tc;
            strobe_q <= boundary;
            if (bclk_fall) begin
                bit_cnt_q <= bit_nxt;
                lrclk_q   <= bit_nxt[5];
                sdata_q   <= sdata_d;
            end

            if (boundary) begin
                if (!fifo_empty) begin
                    {play_l_q, play_r_q} <= mem_q[rd_ptr_q];
                    started_q            <= 1'b1;
                end else begin
                    play_l_q <= '0;
                    play_r_q <= '0;
                end
            end

            if (cmd_clear_status) begin
                underrun_q <= '0;
                framing_q  <= 1'b0;
            end else begin
                if (underrun_inc && (underrun_q != 16'hFFFF))
                    underrun_q <= underrun_q + 16'd1;
                if (framing_set)
                    framing_q <= 1'b1;
            end
        end
    end

    assign dac_ready        = dac_ready_q;
    assign i2s_bclk         = bclk_q;
    assign i2s_lrclk        = lrclk_q;
    assign i2s_sdata        = sdata_q;
    assign frame_strobe     = strobe_q;
    assign sr_underrun_cnt  = underrun_q;
    assign sr_framing_error = framing_q;
    assign sr_fifo_level    = level_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: cycle-count model of the I2S pins plus a pair queue,
// checked every cycle, and directed scenarios with literal expectations.
module tb_i2s_dac_tx;
    localparam int W = 24;
    localparam int D = 4;
    localparam int H = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  dac_data;
    logic          dac_valid, dac_ready, dac_last;
    logic          i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe;
    logic          cmd_clear_status;
    logic [15:0]   sr_underrun_cnt;
    logic          sr_framing_error;
    logic [2:0]    sr_fifo_level;

    i2s_dac_tx #(.AUDIO_WIDTH_P(W), .FIFO_DEPTH_P(D), .BCLK_HALF_P(H)) dut (
        .clk(clk), .rst_n(rst_n), .dac_data(dac_data), .dac_valid(dac_valid),
        .dac_ready(dac_ready), .dac_last(dac_last), .i2s_bclk(i2s_bclk),
        .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata), .frame_strobe(frame_strobe),
        .cmd_clear_status(cmd_clear_status), .sr_underrun_cnt(sr_underrun_cnt),
        .sr_framing_error(sr_framing_error), .sr_fifo_level(sr_fifo_level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // ---------------- model: outputs as a function of cycles since reset ----
    int          k;
    logic [47:0] mq[$];
    logic [W-1:0] cur_l, cur_r, hold_l;
    logic        has_left, started, m_ferr, e_rdy, rst_prev = 1'b0;
    int          m_ur;
    logic        s_v, s_l, s_c;
    logic [W-1:0] s_d;
    logic        loop_mode = 1'b0;
    int          max_lvl = 0;

    task automatic m_reset();
        k = 0; mq.delete(); cur_l = '0; cur_r = '0; hold_l = '0;
        has_left = 1'b0; started = 1'b0; m_ferr = 1'b0; m_ur = 0; e_rdy = 1'b0;
    endtask

    task automatic m_step();
        int m;
        k++;
        m = k / (2 * H);
        if ((k % (2 * H) == 0) && ((m - 1) % 64 == 0)) begin
            if (mq.size() > 0) begin
                {cur_l, cur_r} = mq.pop_front();
                started = 1'b1;
            end else begin
                cur_l = '0; cur_r = '0;
                if (started && m_ur < 65535) m_ur++;
            end
        end
        if (s_v && e_rdy) begin
            if (!has_left) begin
                if (!s_l) begin hold_l = s_d; has_left = 1'b1; end
                else m_ferr = 1'b1;
            end else begin
                if (s_l) begin mq.push_back({hold_l, s_d}); has_left = 1'b0; end
                else begin hold_l = s_d; m_ferr = 1'b1; end
            end
        end
        if (s_c) begin m_ur = 0; m_ferr = 1'b0; end
    endtask

    task automatic m_compare();
        int m, b, p;
        logic e_bclk, e_lr, e_sd, e_fs;
        logic [W-1:0] w;
        e_bclk = ((k / H) % 2) == 1;
        m = k / (2 * H);
        e_lr = 1'b0; e_sd = 1'b0; e_fs = 1'b0;
        if (m >= 1) begin
            b = (m - 1) % 64;
            p = b % 32;
            e_lr = (b >= 32);
            w = (b < 32) ? cur_l : cur_r;
            if (p >= 1 && p <= W) e_sd = w[W - p];
            e_fs = (k % (2 * H) == 0) && (b == 0);
        end
        e_rdy = (k > 0) && (mq.size() < D);
        chk("bclk", i2s_bclk, e_bclk);
        chk("lrclk", i2s_lrclk, e_lr);
        chk("sdata", i2s_sdata, e_sd);
        chk("frame_strobe", frame_strobe, e_fs);
        chk("dac_ready", dac_ready, e_rdy);
        chk("fifo_level", sr_fifo_level, mq.size());
        chk("underrun_cnt", sr_underrun_cnt, m_ur);
        chk("framing_error", sr_framing_error, m_ferr);
    endtask

    always @(negedge clk) begin
        if (!rst_n) m_reset();
        else if (rst_prev) m_step();
        rst_prev = rst_n;
        m_compare();
        if (loop_mode && int'(sr_fifo_level) > max_lvl) max_lvl = int'(sr_fifo_level);
        s_v = dac_valid; s_d = dac_data; s_l = dac_last; s_c = cmd_clear_status;
    end

    // ---------------- driver helpers (inputs change #1 after posedge) -------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last);
        int n = 0;
        dac_valid = 1'b1; dac_data = d; dac_last = last;
        @(negedge clk);
        while (!dac_ready && n < 2000) begin @(negedge clk); n++; end
        if (!dac_ready) tmo("send_beat");
        tick();
        dac_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        send_beat(l, 1'b0);
        send_beat(r, 1'b1);
    endtask

    task automatic wait_strobe_n();
        int n = 0;
        @(negedge clk);
        while (!frame_strobe && n < 1000) begin @(negedge clk); n++; end
        if (!frame_strobe) tmo("wait_strobe");
    endtask

    task automatic wait_strobe();
        wait_strobe_n();
        tick();
    endtask

    task automatic wait_falls(input int cnt);
        int f = 0, n = 0;
        logic pb;
        pb = i2s_bclk;
        while (f < cnt && n < 4000) begin
            @(negedge clk); n++;
            if (pb && !i2s_bclk) f++;
            pb = i2s_bclk;
        end
        if (f < cnt) tmo("wait_falls");
    endtask

    task automatic capture_frame(output logic [63:0] sd, output logic [63:0] lr);
        int b = 1, n = 0;
        logic pb;
        sd = '0; lr = '0;
        wait_strobe_n();
        sd[0] = i2s_sdata; lr[0] = i2s_lrclk; pb = i2s_bclk;
        while (b < 64 && n < 4000) begin
            @(negedge clk); n++;
            if (pb && !i2s_bclk) begin sd[b] = i2s_sdata; lr[b] = i2s_lrclk; b++; end
            pb = i2s_bclk;
        end
        if (b < 64) tmo("capture_frame");
        tick();
    endtask

    function automatic logic [W-1:0] dec(input logic [63:0] sd, input int base);
        logic [W-1:0] w;
        for (int p = 1; p <= W; p++) w[W - p] = sd[base + p];
        return w;
    endfunction

    task automatic clear_pulse();
        cmd_clear_status = 1'b1;
        tick();
        cmd_clear_status = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] sd, lr;
        time t0;
        int n;
        rst_n = 1'b0; dac_valid = 1'b0; dac_data = '0; dac_last = 1'b0;
        cmd_clear_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bclk", i2s_bclk, 0);
        chk("rst_ready", dac_ready, 0);
        chk("rst_level", sr_fifo_level, 0);
        rst_n = 1'b1;

        // Frame content and pin timing for a single pair
        wait_strobe();
        send_pair(24'h800001, 24'h7FFFFE);
        capture_frame(sd, lr);
        chk("t1_sdata_bits", sd, 64'h00FF_FFFC_0100_0002);
        chk("t1_lrclk_bits", lr, 64'hFFFF_FFFF_0000_0000);
        chk("t1_left_word", dec(sd, 0), 24'h800001);
        chk("t1_right_word", dec(sd, 32), 24'h7FFFFE);
        wait_falls(1);
        t0 = $time;
        wait_falls(1);
        chk("t1_bclk_period_clk", ($time - t0) / 10, 4);
        tick();

        // Back-pressure: 5 pairs into a 4-deep FIFO
        wait_strobe();
        for (int i = 0; i < 4; i++) send_pair(24'(i + 1), 24'(i + 16));
        chk("t2_ready_full", dac_ready, 0);
        chk("t2_level_full", sr_fifo_level, 4);
        send_pair(24'h00ABCD, 24'h00DCBA);
        chk("t2_level_after_pop", sr_fifo_level, 4);

        // Underrun counting and clear
        n = 0;
        while (sr_fifo_level != 0 && n < 3000) begin tick(); n++; end
        if (sr_fifo_level != 0) tmo("t3_drain");
        wait_strobe();
        clear_pulse();
        send_pair(24'h123456, 24'h654321);
        send_pair(24'h0F0F0F, 24'hF0F0F0);
        repeat (5) wait_strobe();
        chk("t3_underrun_3", sr_underrun_cnt, 3);
        clear_pulse();
        chk("t3_underrun_clr", sr_underrun_cnt, 0);
        wait_strobe();
        t0 = $time;
        wait_strobe();
        chk("t3_strobe_spacing", ($time - t0) / 10, 256);

        // Framing violations
        clear_pulse();
        chk("t4_ferr_clr", sr_framing_error, 0);
        wait_strobe();
        send_beat(24'h000005, 1'b1);
        send_beat(24'h000010, 1'b0);
        send_beat(24'h000020, 1'b0);
        send_beat(24'h000030, 1'b1);
        chk("t4_ferr_set", sr_framing_error, 1);
        chk("t4_one_pair", sr_fifo_level, 1);
        capture_frame(sd, lr);
        chk("t4_left_word", dec(sd, 0), 24'h000020);
        chk("t4_right_word", dec(sd, 32), 24'h000030);

        // Reset mid-frame with pairs queued
        wait_strobe();
        for (int i = 0; i < 3; i++) send_pair(24'(i + 7), 24'(i + 9));
        wait_strobe_n();
        wait_falls(40);
        tick();
        chk("t5_level_pre", sr_fifo_level, 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_bclk", i2s_bclk, 0);
        chk("t5_rst_lrclk", i2s_lrclk, 0);
        chk("t5_rst_sdata", i2s_sdata, 0);
        chk("t5_rst_ready", dac_ready, 0);
        chk("t5_rst_level", sr_fifo_level, 0);
        chk("t5_rst_ferr", sr_framing_error, 0);
        repeat (4) tick();
        rst_n = 1'b1;
        tick();
        chk("t5_level_post", sr_fifo_level, 0);
        chk("t5_ready_post", dac_ready, 1);
        wait_strobe();
        chk("t5_no_underrun_a", sr_underrun_cnt, 0);
        wait_strobe();
        chk("t5_no_underrun_b", sr_underrun_cnt, 0);

        // Strobe-paced source
        loop_mode = 1'b1;
        for (int f = 0; f < 200; f++) begin
            wait_strobe();
            send_pair(24'($urandom), 24'($urandom));
        end
        wait_strobe();
        loop_mode = 1'b0;
        chk("t6_underrun_zero", sr_underrun_cnt, 0);
        chk("t6_level_le2", (max_lvl <= 2), 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
